// File: rtl/hwpe_ctrl_package.sv
// Shared types for the HWPE control job scheduler: context/FSM enums and the
// status flags bundle exported towards the register file.
package hwpe_ctrl_package;

  // Widest context index carried in the flags bundle (up to 256 contexts).
  localparam int SCHED_CTX_W = 8;

  typedef enum logic [1:0] {
    CTX_FREE,
    CTX_ACQUIRED,
    CTX_QUEUED,
    CTX_RUNNING
  } ctx_state_t;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_START,
    SCHED_RUN,
    SCHED_RETIRE
  } job_sched_fsm_t;

  typedef struct packed {
    logic [SCHED_CTX_W-1:0] pointer_context;
    logic [SCHED_CTX_W-1:0] running_context;
    logic                   busy;
    logic [SCHED_CTX_W:0]   nb_free;
  } flags_job_sched_t;

endpackage

// File: rtl/hwpe_ctrl_ctx_ring.sv
// Ring of job contexts: per-context state and owner, plus the programming
// pointer and the running pointer, both wrapping modulo N_CONTEXT.
module hwpe_ctrl_ctx_ring
  import hwpe_ctrl_package::*;
#(
  parameter int N_CONTEXT = 2,
  parameter int N_CORES   = 16,
  localparam int CW = $clog2(N_CONTEXT),
  localparam int OW = $clog2(N_CORES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          grant,
  input  logic [OW-1:0] grant_core,
  input  logic          queue,
  input  logic          start,
  input  logic          retire,
  output logic [CW-1:0] ptr,
  output logic [CW-1:0] rptr,
  output logic          ptr_free,
  output logic          lock,
  output logic          run_queued,
  output logic [OW-1:0] run_owner,
  output logic [CW:0]   nb_free
);

  ctx_state_t              state_q [N_CONTEXT];
  logic [N_CONTEXT-1:0][OW-1:0] owner_q;

  // grant/queue touch the slot at ptr and start/retire the slot at rptr; the
  // state guards on each make those two slots distinct whenever both fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CONTEXT; i++) state_q[i] <= CTX_FREE;
      owner_q <= '0;
      ptr     <= '0;
      rptr    <= '0;
    end else if (clear) begin
      for (int i = 0; i < N_CONTEXT; i++) state_q[i] <= CTX_FREE;
      owner_q <= '0;
      ptr     <= '0;
      rptr    <= '0;
    end else begin
      if (grant) begin
        state_q[ptr] <= CTX_ACQUIRED;
        owner_q[ptr] <= grant_core;
      end
      if (queue) begin
        state_q[ptr] <= CTX_QUEUED;
        ptr          <= ptr + CW'(1);
      end
      if (start) state_q[rptr] <= CTX_RUNNING;
      if (retire) begin
        state_q[rptr] <= CTX_FREE;
        rptr          <= rptr + CW'(1);
      end
    end
  end

  always_comb begin
    nb_free = '0;
    lock    = 1'b0;
    for (int i = 0; i < N_CONTEXT; i++) begin
      nb_free = nb_free + (CW+1)'(state_q[i] == CTX_FREE);
      lock    = lock | (state_q[i] == CTX_ACQUIRED);
    end
  end

  assign ptr_free   = (state_q[ptr] == CTX_FREE);
  assign run_queued = (state_q[rptr] == CTX_QUEUED);
  assign run_owner  = owner_q[rptr];

endmodule

// File: rtl/hwpe_ctrl_job_sched.sv
// HWPE job/context scheduler: acquire/trigger bookkeeping and engine sequencing.
// Optional HWPE_CTRL_JOB_SCHED_WATCHDOG_EN adds a RUN-phase timeout.
module hwpe_ctrl_job_sched
  import hwpe_ctrl_package::*;
#(
  parameter int N_CONTEXT    = 2,
  parameter int N_CORES      = 16,
  parameter int JOB_ID_WIDTH = 8
`ifdef HWPE_CTRL_JOB_SCHED_WATCHDOG_EN
  , parameter int WATCHDOG_CYCLES = 65535
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         acquire_i,
  input  logic [$clog2(N_CORES)-1:0]   acquire_core_i,
  output logic                         acquire_ok_o,
  output logic [JOB_ID_WIDTH-1:0]      acquire_id_o,
  input  logic                         trigger_i,
  output logic                         start_o,
  input  logic                         engine_done_i,
  output logic [$clog2(N_CONTEXT)-1:0] pointer_context_o,
  output logic [$clog2(N_CONTEXT)-1:0] running_context_o,
  output logic [N_CORES-1:0]           evt_o,
`ifdef HWPE_CTRL_JOB_SCHED_WATCHDOG_EN
  output logic                         timeout_o,
`endif
  output logic                         busy_o,
  output logic [$clog2(N_CONTEXT):0]   nb_free_o
);

  localparam int CW = $clog2(N_CONTEXT);
  localparam int OW = $clog2(N_CORES);

  job_sched_fsm_t          fsm_q, fsm_d;
  logic [JOB_ID_WIDTH-1:0] job_id_q;
  logic                    grant, queue, start, retire, wd_hit;
  logic [CW-1:0]           ptr, rptr;
  logic                    ptr_free, lock, run_queued;
  logic [OW-1:0]           run_owner;
  logic [CW:0]             nb_free;
  flags_job_sched_t        flags;
  logic                    unused_flags;

  // Single lock: one job may be programmed at a time, and only into a free slot.
  assign grant = acquire_i & ~clear_i & ptr_free & ~lock;
  assign queue = trigger_i & ~clear_i & lock;

  hwpe_ctrl_ctx_ring #(
    .N_CONTEXT (N_CONTEXT),
    .N_CORES   (N_CORES)
  ) i_ring (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear      (clear_i),
    .grant      (grant),
    .grant_core (acquire_core_i),
    .queue      (queue),
    .start      (start),
    .retire     (retire),
    .ptr        (ptr),
    .rptr       (rptr),
    .ptr_free   (ptr_free),
    .lock       (lock),
    .run_queued (run_queued),
    .run_owner  (run_owner),
    .nb_free    (nb_free)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      job_id_q <= '0;
    else if (clear_i) job_id_q <= '0;
    else if (grant)   job_id_q <= job_id_q + JOB_ID_WIDTH'(1);
  end

  assign acquire_ok_o = grant;
  assign acquire_id_o = grant ? job_id_q : '0;

`ifdef HWPE_CTRL_JOB_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WDW-1:0] wd_cnt_q;
  logic           timed_out_q;

  // Fires on the RUN cycle that completes WATCHDOG_CYCLES cycles of RUN.
  assign wd_hit = (fsm_q == SCHED_RUN) && !engine_done_i &&
                  (wd_cnt_q == WDW'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else if (clear_i) begin
      wd_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      timed_out_q <= wd_hit;
      if (fsm_q == SCHED_START)    wd_cnt_q <= '0;
      else if (fsm_q == SCHED_RUN) wd_cnt_q <= wd_cnt_q + WDW'(1);
    end
  end

  assign timeout_o = (fsm_q == SCHED_RETIRE) & timed_out_q;
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      fsm_q <= SCHED_IDLE;
    else if (clear_i) fsm_q <= SCHED_IDLE;
    else              fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      SCHED_IDLE:   if (run_queued) fsm_d = SCHED_START;
      SCHED_START:  fsm_d = SCHED_RUN;
      SCHED_RUN:    if (engine_done_i || wd_hit) fsm_d = SCHED_RETIRE;
      SCHED_RETIRE: fsm_d = SCHED_IDLE;
      default:      fsm_d = SCHED_IDLE;
    endcase
  end

  always_comb begin
    start  = (fsm_q == SCHED_START);
    retire = (fsm_q == SCHED_RETIRE);
    evt_o  = '0;
    if (retire) evt_o[run_owner] = 1'b1;
  end

  assign start_o = start;

  assign flags.pointer_context = SCHED_CTX_W'(ptr);
  assign flags.running_context = SCHED_CTX_W'(rptr);
  assign flags.busy            = (nb_free != (CW+1)'(N_CONTEXT));
  assign flags.nb_free         = (SCHED_CTX_W+1)'(nb_free);

  assign pointer_context_o = flags.pointer_context[CW-1:0];
  assign running_context_o = flags.running_context[CW-1:0];
  assign busy_o            = flags.busy;
  assign nb_free_o         = flags.nb_free[CW:0];
  assign unused_flags      = ^flags;

endmodule

// File: tb/tb_hwpe_ctrl_job_sched.sv
// Directed self-checking bench for hwpe_ctrl_job_sched (default 2 contexts,
// 16 cores, 8-bit job IDs); exercises the watchdog when its macro is defined.
module tb_hwpe_ctrl_job_sched;

  logic        clk = 1'b0;
  logic        rst_n, clear, acquire, trigger, engine_done;
  logic [3:0]  acquire_core;
  logic        acquire_ok, start, busy;
  logic [7:0]  acquire_id;
  logic [0:0]  pointer_context, running_context;
  logic [15:0] evt;
  logic [1:0]  nb_free;
`ifdef HWPE_CTRL_JOB_SCHED_WATCHDOG_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hwpe_ctrl_job_sched #(
    .N_CONTEXT    (2),
    .N_CORES      (16),
    .JOB_ID_WIDTH (8)
`ifdef HWPE_CTRL_JOB_SCHED_WATCHDOG_EN
    , .WATCHDOG_CYCLES (10)
`endif
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .clear_i           (clear),
    .acquire_i         (acquire),
    .acquire_core_i    (acquire_core),
    .acquire_ok_o      (acquire_ok),
    .acquire_id_o      (acquire_id),
    .trigger_i         (trigger),
    .start_o           (start),
    .engine_done_i     (engine_done),
    .pointer_context_o (pointer_context),
    .running_context_o (running_context),
    .evt_o             (evt),
`ifdef HWPE_CTRL_JOB_SCHED_WATCHDOG_EN
    .timeout_o         (timeout),
`endif
    .busy_o            (busy),
    .nb_free_o         (nb_free)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the start pulse; a missing pulse counts as a failure.
  task automatic wait_start(input string tag);
    int n = 0;
    while (start !== 1'b1 && n < 10) begin
      next();
      n++;
    end
    chk(tag, 32'(start), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; acquire = 1'b0; trigger = 1'b0;
    engine_done = 1'b0; acquire_core = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ok",    32'(acquire_ok), 0);
    chk("rst_id",    32'(acquire_id), 0);
    chk("rst_nfree", 32'(nb_free), 2);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_evt",   32'(evt), 0);
    chk("rst_ptr",   32'({pointer_context, running_context}), 0);
    rst_n = 1'b1;
    next();

    // single job, core 3
    acquire = 1'b1; acquire_core = 4'd3; #1;
    chk("t1_ok", 32'(acquire_ok), 1);
    chk("t1_id", 32'(acquire_id), 0);
    next(); acquire = 1'b0; #1;
    chk("t1_nfree", 32'(nb_free), 1);
    chk("t1_busy",  32'(busy), 1);
    trigger = 1'b1; next(); trigger = 1'b0; #1;
    chk("t1_start_t1", 32'(start), 0);
    next();
    chk("t1_start_t2", 32'(start), 1);
    next();
    engine_done = 1'b1; #1;
    chk("t1_evt_d", 32'(evt), 0);
    next(); engine_done = 1'b0; #1;
    chk("t1_evt", 32'(evt), 32'h0008);
    next();
    chk("t1_nfree_end", 32'(nb_free), 2);
    chk("t1_busy_end",  32'(busy), 0);

    clear = 1'b1; next(); clear = 1'b0; #1;
    chk("clr_ptr", 32'({pointer_context, running_context}), 0);

    // two jobs queued while the engine is busy
    acquire = 1'b1; acquire_core = 4'd1; #1;
    chk("t2_ok0", 32'(acquire_ok), 1);
    chk("t2_id0", 32'(acquire_id), 0);
    next(); acquire = 1'b0; trigger = 1'b1;
    next(); trigger = 1'b0; acquire = 1'b1; acquire_core = 4'd2; #1;
    chk("t2_ok1", 32'(acquire_ok), 1);
    chk("t2_id1", 32'(acquire_id), 1);
    next(); acquire = 1'b0; trigger = 1'b1; #1;
    chk("t2_start0", 32'(start), 1);
    next(); trigger = 1'b0; acquire = 1'b1; acquire_core = 4'd7; #1;
    chk("t2_full_ok", 32'(acquire_ok), 0);
    chk("t2_full_id", 32'(acquire_id), 0);
    chk("t2_full_nfree", 32'(nb_free), 0);
    next(); acquire = 1'b0; engine_done = 1'b1;
    next(); engine_done = 1'b0; #1;
    chk("t2_evt0", 32'(evt), 32'h0002);
    next();
    chk("t2_start_d2", 32'(start), 0);
    chk("t2_nfree_d2", 32'(nb_free), 1);
    next();
    chk("t2_start_d3", 32'(start), 1);
    chk("t2_running", 32'(running_context), 1);
    next(); engine_done = 1'b1;
    next(); engine_done = 1'b0; #1;
    chk("t2_evt1", 32'(evt), 32'h0004);
    next();
    chk("t2_busy_end", 32'(busy), 0);

    // lock: second acquire and acquire+trigger are both denied
    acquire = 1'b1; acquire_core = 4'd0; #1;
    chk("t3_ok", 32'(acquire_ok), 1);
    chk("t3_id", 32'(acquire_id), 2);
    next(); acquire_core = 4'd5; #1;
    chk("t3_deny", 32'(acquire_ok), 0);
    next(); trigger = 1'b1; #1;
    chk("t3_deny_trig", 32'(acquire_ok), 0);
    next(); acquire = 1'b0; trigger = 1'b0;
    wait_start("t3_start");
    next(); engine_done = 1'b1;
    next(); engine_done = 1'b0; #1;
    chk("t3_evt", 32'(evt), 32'h0001);
    next();

    // job ID and pointer wrap
    clear = 1'b1; next(); clear = 1'b0;
    for (int i = 0; i < 257; i++) begin
      acquire = 1'b1; acquire_core = 4'(i); #1;
      chk("wrap_ok", 32'(acquire_ok), 1);
      chk("wrap_id", 32'(acquire_id), 32'(i % 256));
      next(); acquire = 1'b0; trigger = 1'b1;
      next(); trigger = 1'b0; #1;
      chk("wrap_ptr", 32'(pointer_context), 32'((i + 1) % 2));
      wait_start("wrap_start");
      next(); engine_done = 1'b1;
      next(); engine_done = 1'b0;
      next();
    end

    // soft clear while running swallows the completion
    acquire = 1'b1; acquire_core = 4'd4;
    next(); acquire = 1'b0; trigger = 1'b1;
    next(); trigger = 1'b0;
    wait_start("clr_start");
    next(); clear = 1'b1;
    next(); clear = 1'b0; #1;
    chk("clr_busy",  32'(busy), 0);
    chk("clr_nfree", 32'(nb_free), 2);
    engine_done = 1'b1;
    next(); engine_done = 1'b0; #1;
    chk("clr_evt", 32'(evt), 0);
    chk("clr_start_after", 32'(start), 0);

    // async reset mid-run takes effect before the next edge
    acquire = 1'b1; acquire_core = 4'd6;
    next(); acquire = 1'b0; trigger = 1'b1;
    next(); trigger = 1'b0;
    wait_start("rst_start");
    next(); rst_n = 1'b0; #1;
    chk("arst_busy",  32'(busy), 0);
    chk("arst_nfree", 32'(nb_free), 2);
    chk("arst_ptr",   32'(pointer_context), 0);
    next(); rst_n = 1'b1;
    next();

    for (int i = 0; i < 3; i++) begin
      chk("empty_start", 32'(start), 0);
      next();
    end

`ifdef HWPE_CTRL_JOB_SCHED_WATCHDOG_EN
    begin
      int n = 0;
      acquire = 1'b1; acquire_core = 4'd9;
      next(); acquire = 1'b0; trigger = 1'b1;
      next(); trigger = 1'b0;
      wait_start("wd_start");
      while (evt == 16'h0 && n < 40) begin
        next();
        n++;
      end
      chk("wd_lat",     32'(n), 11);
      chk("wd_timeout", 32'(timeout), 1);
      chk("wd_evt",     32'(evt), 32'h0200);
      next();
      chk("wd_nfree",   32'(nb_free), 2);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
